pipeline_ctrl: RTL and testbench

//  Consumes the hazard unit's data-hazard flag plus branch, cache-busy and fence requests.

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/pipeline_ctrl_perf_counters.sv | 58 +++++
 rtl/pipeline_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   pipe_state_e : controller FSM state encoding (RUN / REDIR / FENCE)
//   DRAIN_W      : width of the fence drain counter (DRAIN_CYCLES is 1..7)
//   PC_W         : program counter width
//   nop_instr()  : instruction encoding the datapath loads on flush/bubble
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_REDIR = 2'b01,
        ST_FENCE = 2'b10
    } pipe_state_e;

    localparam int DRAIN_W = 3;
    localparam int PC_W    = 32;

    // addi x0, x0, 0 -- what "flush" and "bubble" put into IF/ID and ID/EX.
    function automatic logic [31:0] nop_instr();
        return 32'h0000_0013;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counters.sv
// Pipeline performance counters, present only when PIPE_PERF_COUNTERS_EN is
// defined (the whole module is compiled out otherwise).
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (counters clear to 0)
//   i_if_ce        IF enable; a cycle with it low counts as a stall
//   i_id_flush     IF/ID flush; counts flush cycles
//   i_wb_ce        MA/WB enable; qualifies retirement
//   i_wb_valid     instruction retiring this cycle
//   o_cyc/o_ret/o_stl/o_flu  cycle / retired / stall / flush counts (wrap)
`ifdef PIPE_PERF_COUNTERS_EN
module pipeline_ctrl_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_ce,
    input  logic             i_id_flush,
    input  logic             i_wb_ce,
    input  logic             i_wb_valid,
    output logic [CNT_W-1:0] o_cyc,
    output logic [CNT_W-1:0] o_ret,
    output logic [CNT_W-1:0] o_stl,
    output logic [CNT_W-1:0] o_flu
);

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] stl_q, stl_d;
    logic [CNT_W-1:0] flu_q, flu_d;

    always_comb begin
        cyc_d = cyc_q + CNT_W'(1);
        ret_d = ret_q + CNT_W'(i_wb_valid && i_wb_ce);
        stl_d = stl_q + CNT_W'(!i_if_ce);
        flu_d = flu_q + CNT_W'(i_id_flush);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cyc_q <= '0;
            ret_q <= '0;
            stl_q <= '0;
            flu_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
            stl_q <= stl_d;
            flu_q <= flu_d;
        end
    end

    assign o_cyc = cyc_q;
    assign o_ret = ret_q;
    assign o_stl = stl_q;
    assign o_flu = flu_q;

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// Pipeline controller for the 5-stage core (IF ID EX MA WB).
// Turns the hazard unit's data-hazard flag and the branch / cache-busy / fence
// requests into per-stage clock enables, bubbles, flushes and PC redirects.
// Holds the multi-cycle state the hazard unit lacks: a branch redirect waiting
// for the icache (REDIR) and the FENCE.I drain (FENCE).
// Optional feature macro: PIPE_PERF_COUNTERS_EN (performance counters; when
// undefined the o_perf_* outputs are tied to 0).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_hz_data           data hazard for instruction in ID
//   i_br_taken/i_br_pc  EX resolved taken branch and its target
//   i_ic_busy           fetch has no valid instruction this cycle
//   i_dc_busy           MA access not complete (freezes everything)
//   i_fence_req         FENCE.I in EX
//   i_wb_valid          instruction retiring (perf only)
//   o_*_ce              stage register enables
//   o_id_flush          load NOP into IF/ID
//   o_ex_bubble         load NOP into ID/EX
//   o_pc_load/o_pc_tgt  PC redirect and its target (live or held)
//   o_fence_done        one-cycle pulse at end of fence drain
//   o_perf_*            cycle / retired / stall / flush counters
//   o_dbg_state         current FSM state
// All outputs are combinational from inputs and registered state, so enables
// take effect on the same clock edge.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hz_data,
    input  logic             i_br_taken,
    input  logic [31:0]      i_br_pc,
    input  logic             i_ic_busy,
    input  logic             i_dc_busy,
    input  logic             i_fence_req,
    input  logic             i_wb_valid,
    output logic             o_if_ce,
    output logic             o_id_ce,
    output logic             o_ex_ce,
    output logic             o_ma_ce,
    output logic             o_wb_ce,
    output logic             o_id_flush,
    output logic             o_ex_bubble,
    output logic             o_pc_load,
    output logic [31:0]      o_pc_tgt,
    output logic             o_fence_done,
    output logic [CNT_W-1:0] o_perf_cyc,
    output logic [CNT_W-1:0] o_perf_ret,
    output logic [CNT_W-1:0] o_perf_stl,
    output logic [CNT_W-1:0] o_perf_flu,
    output logic [1:0]       o_dbg_state
);

    pipe_state_e        state_q, state_d;
    logic [PC_W-1:0]    held_pc_q, held_pc_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic if_ce, id_ce, ex_ce, ma_ce, wb_ce;
    logic id_flush, ex_bubble, pc_load, fence_done;

    always_comb begin
        state_d    = state_q;
        held_pc_d  = held_pc_q;
        drain_d    = drain_q;
        if_ce      = 1'b1;
        id_ce      = 1'b1;
        ex_ce      = 1'b1;
        ma_ce      = 1'b1;
        wb_ce      = 1'b1;
        id_flush   = 1'b0;
        ex_bubble  = 1'b0;
        pc_load    = 1'b0;
        fence_done = 1'b0;

        if (i_rst) begin
            if_ce     = 1'b0;
            id_ce     = 1'b0;
            ex_ce     = 1'b0;
            ma_ce     = 1'b0;
            wb_ce     = 1'b0;
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
        end else if (i_dc_busy) begin
            // Whole pipe frozen; state holds and requests are seen again later.
            if_ce = 1'b0;
            id_ce = 1'b0;
            ex_ce = 1'b0;
            ma_ce = 1'b0;
            wb_ce = 1'b0;
        end else if (i_br_taken) begin
            // A taken branch overrides any pending redirect (latest wins)
            // and aborts a fence drain without a done pulse.
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
            drain_d   = '0;
            if (i_ic_busy) begin
                held_pc_d = i_br_pc;
                state_d   = ST_REDIR;
            end else begin
                pc_load = 1'b1;
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_REDIR: begin
                    // Keep IF/ID empty until fetch can take the held target.
                    id_flush = 1'b1;
                    if (!i_ic_busy) begin
                        pc_load = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_FENCE: begin
                    if_ce     = 1'b0;
                    id_ce     = 1'b0;
                    ex_bubble = 1'b1;
                    if (drain_q <= DRAIN_W'(1)) begin
                        fence_done = 1'b1;
                        drain_d    = '0;
                        state_d    = ST_RUN;
                    end else begin
                        drain_d = drain_q - DRAIN_W'(1);
                    end
                end
                default: begin
                    if (i_fence_req) begin
                        // The fence itself moves on to MA this cycle; freezing
                        // starts with the first FENCE cycle.
                        state_d = ST_FENCE;
                        drain_d = DRAIN_W'(DRAIN_CYCLES);
                    end else if (i_hz_data) begin
                        if_ce     = 1'b0;
                        id_ce     = 1'b0;
                        ex_bubble = 1'b1;
                    end else if (i_ic_busy) begin
                        // PC keeps retrying; the missing fetch becomes a NOP.
                        id_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_RUN;
            held_pc_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            held_pc_q <= held_pc_d;
            drain_q   <= drain_d;
        end
    end

    assign o_if_ce      = if_ce;
    assign o_id_ce      = id_ce;
    assign o_ex_ce      = ex_ce;
    assign o_ma_ce      = ma_ce;
    assign o_wb_ce      = wb_ce;
    assign o_id_flush   = id_flush;
    assign o_ex_bubble  = ex_bubble;
    assign o_pc_load    = pc_load;
    assign o_fence_done = fence_done;
    // Live target while a branch is presented, otherwise the held one.
    assign o_pc_tgt     = i_br_taken ? i_br_pc : held_pc_q;
    assign o_dbg_state  = state_q;

`ifdef PIPE_PERF_COUNTERS_EN
    pipeline_ctrl_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_if_ce    (if_ce),
        .i_id_flush (id_flush),
        .i_wb_ce    (wb_ce),
        .i_wb_valid (i_wb_valid),
        .o_cyc      (o_perf_cyc),
        .o_ret      (o_perf_ret),
        .o_stl      (o_perf_stl),
        .o_flu      (o_perf_flu)
    );
`else
    logic unused_wb_valid;
    assign unused_wb_valid = i_wb_valid;
    assign o_perf_cyc = '0;
    assign o_perf_ret = '0;
    assign o_perf_stl = '0;
    assign o_perf_flu = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios with literal expectations plus a
// short random run, all checked every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int DRAIN = 3;
    localparam int CW    = 32;

    logic          clk;
    logic          rst, hz, br, ic, dc, fence, wb;
    logic [31:0]   br_pc;
    logic          if_ce, id_ce, ex_ce, ma_ce, wb_ce;
    logic          id_flush, ex_bubble, pc_load, fence_done;
    logic [31:0]   pc_tgt;
    logic [CW-1:0] perf_cyc, perf_ret, perf_stl, perf_flu;
    logic [1:0]    dbg_state;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .CNT_W(CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_hz_data    (hz),
        .i_br_taken   (br),
        .i_br_pc      (br_pc),
        .i_ic_busy    (ic),
        .i_dc_busy    (dc),
        .i_fence_req  (fence),
        .i_wb_valid   (wb),
        .o_if_ce      (if_ce),
        .o_id_ce      (id_ce),
        .o_ex_ce      (ex_ce),
        .o_ma_ce      (ma_ce),
        .o_wb_ce      (wb_ce),
        .o_id_flush   (id_flush),
        .o_ex_bubble  (ex_bubble),
        .o_pc_load    (pc_load),
        .o_pc_tgt     (pc_tgt),
        .o_fence_done (fence_done),
        .o_perf_cyc   (perf_cyc),
        .o_perf_ret   (perf_ret),
        .o_perf_stl   (perf_stl),
        .o_perf_flu   (perf_flu),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- behavioural model ----------------
    // Pending redirect flag + target, fence cycles left, and counters.
    bit          m_redir;
    logic [31:0] m_target;
    int          m_drain_left;
    logic [31:0] m_cyc, m_ret, m_stl, m_flu;

    typedef struct packed {
        logic [4:0]  ce;      // {if, id, ex, ma, wb}
        logic        flush;
        logic        bubble;
        logic        pc_load;
        logic [31:0] tgt;
        logic        done;
        logic [1:0]  st;
    } exp_t;

    function automatic exp_t model_expect();
        exp_t e;
        e.ce      = 5'b11111;
        e.flush   = 1'b0;
        e.bubble  = 1'b0;
        e.pc_load = 1'b0;
        e.tgt     = 32'h0;
        e.done    = 1'b0;
        e.st      = m_redir ? 2'b01 : ((m_drain_left != 0) ? 2'b10 : 2'b00);
        if (rst) begin
            e.ce = 5'b00000; e.flush = 1'b1; e.bubble = 1'b1;
        end else if (dc) begin
            e.ce = 5'b00000;
        end else if (br) begin
            e.flush = 1'b1; e.bubble = 1'b1; e.pc_load = !ic; e.tgt = br_pc;
        end else if (m_redir) begin
            e.flush = 1'b1; e.pc_load = !ic; e.tgt = m_target;
        end else if (m_drain_left != 0) begin
            e.ce = 5'b00111; e.bubble = 1'b1; e.done = (m_drain_left == 1);
        end else if (fence) begin
            e.ce = 5'b11111;
        end else if (hz) begin
            e.ce = 5'b00111; e.bubble = 1'b1;
        end else if (ic) begin
            e.flush = 1'b1;
        end
        return e;
    endfunction

    // Called at each rising edge with the inputs that were applied before it.
    task automatic model_advance();
        exp_t e;
        e = model_expect();
        if (rst) begin
            m_redir = 0; m_target = 32'h0; m_drain_left = 0;
            m_cyc = 0; m_ret = 0; m_stl = 0; m_flu = 0;
        end else begin
            m_cyc = m_cyc + 1;
            if (!e.ce[4]) m_stl = m_stl + 1;
            if (e.flush) m_flu = m_flu + 1;
            if (wb && e.ce[0]) m_ret = m_ret + 1;
            if (dc) begin
                // frozen
            end else if (br) begin
                m_drain_left = 0;
                m_redir = ic;
                if (ic) m_target = br_pc;
            end else if (m_redir) begin
                if (!ic) m_redir = 0;
            end else if (m_drain_left != 0) begin
                m_drain_left = m_drain_left - 1;
            end else if (fence) begin
                m_drain_left = DRAIN;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        exp_t e;
        e = model_expect();
        check("ce_vec", {27'd0, if_ce, id_ce, ex_ce, ma_ce, wb_ce}, {27'd0, e.ce});
        check("id_flush", {31'd0, id_flush}, {31'd0, e.flush});
        check("ex_bubble", {31'd0, ex_bubble}, {31'd0, e.bubble});
        check("pc_load", {31'd0, pc_load}, {31'd0, e.pc_load});
        if (e.pc_load) check("pc_tgt", pc_tgt, e.tgt);
        check("fence_done", {31'd0, fence_done}, {31'd0, e.done});
        check("dbg_state", {30'd0, dbg_state}, {30'd0, e.st});
`ifdef PIPE_PERF_COUNTERS_EN
        check("perf_cyc", perf_cyc, m_cyc);
        check("perf_ret", perf_ret, m_ret);
        check("perf_stl", perf_stl, m_stl);
        check("perf_flu", perf_flu, m_flu);
`else
        check("perf_cyc", perf_cyc, 32'h0);
        check("perf_ret", perf_ret, 32'h0);
        check("perf_stl", perf_stl, 32'h0);
        check("perf_flu", perf_flu, 32'h0);
`endif
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare_all();
        end
    end

    // ---------------- driver ----------------
    // Advances the model at the edge, applies new inputs 1 time unit later and
    // returns just before the falling edge so literal checks can follow.
    task automatic drive(input logic r, input logic h, input logic b, input logic [31:0] pc,
                         input logic i, input logic d, input logic f, input logic w);
        @(posedge clk);
        model_advance();
        #1;
        rst = r; hz = h; br = b; br_pc = pc; ic = i; dc = d; fence = f; wb = w;
        #3;
    endtask

    task automatic idle(input logic i);
        drive(0, 0, 0, 32'h0, i, 0, 0, 0);
    endtask

    int done_cnt;

    initial begin
        rst = 1; hz = 0; br = 0; br_pc = 32'h0; ic = 0; dc = 0; fence = 0; wb = 0;
        m_redir = 0; m_target = 0; m_drain_left = 0;
        m_cyc = 0; m_ret = 0; m_stl = 0; m_flu = 0;

        // Reset
        drive(1, 0, 0, 32'h0, 0, 0, 0, 0);
        chk_en = 1;
        drive(1, 0, 0, 32'h0, 0, 0, 0, 0);
        check("rst_if_ce", {31'd0, if_ce}, 32'd0);
        check("rst_wb_ce", {31'd0, wb_ce}, 32'd0);
        check("rst_flush", {31'd0, id_flush}, 32'd1);
        check("rst_bubble", {31'd0, ex_bubble}, 32'd1);
        check("rst_pc_load", {31'd0, pc_load}, 32'd0);
        idle(0);
        check("post_rst_cyc", perf_cyc, 32'd0);
        check("post_rst_if_ce", {31'd0, if_ce}, 32'd1);

        // Data hazard, two cycles
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 32'h0, 0, 0, 0, 1);
            check("hz_if_ce", {31'd0, if_ce}, 32'd0);
            check("hz_id_ce", {31'd0, id_ce}, 32'd0);
            check("hz_bubble", {31'd0, ex_bubble}, 32'd1);
            check("hz_exmawb_ce", {29'd0, ex_ce, ma_ce, wb_ce}, 32'd7);
        end

        // Immediate branch
        drive(0, 0, 1, 32'h100, 0, 0, 0, 1);
        check("br_pc_load", {31'd0, pc_load}, 32'd1);
        check("br_tgt", pc_tgt, 32'h100);
        check("br_flush_bubble", {30'd0, id_flush, ex_bubble}, 32'd3);

        // Branch while icache busy -> REDIR for three cycles, load on 4th
        drive(0, 0, 1, 32'h200, 1, 0, 0, 0);
        check("redir1_flush", {31'd0, id_flush}, 32'd1);
        check("redir1_no_load", {31'd0, pc_load}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            idle(1);
            check("redir_flush", {31'd0, id_flush}, 32'd1);
            check("redir_no_load", {31'd0, pc_load}, 32'd0);
            check("redir_state", {30'd0, dbg_state}, 32'd1);
        end
        idle(0);
        check("redir_load", {31'd0, pc_load}, 32'd1);
        check("redir_tgt", pc_tgt, 32'h200);
        idle(0);
        check("redir_back_run", {30'd0, dbg_state}, 32'd0);

        // Fence with dc_busy on the 2nd frozen cycle
        drive(0, 0, 0, 32'h0, 0, 0, 1, 0);
        check("fence_req_if_ce", {31'd0, if_ce}, 32'd1);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 32'h0, 0, (k == 1), 0, 0);
            check("fence_if_ce", {31'd0, if_ce}, 32'd0);
            check("fence_done_k", {31'd0, fence_done}, (k == 3) ? 32'd1 : 32'd0);
            if (fence_done) done_cnt++;
        end
        idle(0);
        check("fence_after_if_ce", {31'd0, if_ce}, 32'd1);
        check("fence_done_once", done_cnt, 32'd1);

        // dc_busy beats branch and hazard; branch taken once dc_busy drops
        drive(0, 1, 1, 32'h300, 0, 1, 0, 1);
        check("dc_all_ce", {27'd0, if_ce, id_ce, ex_ce, ma_ce, wb_ce}, 32'd0);
        check("dc_no_load", {31'd0, pc_load}, 32'd0);
        check("dc_no_flush", {31'd0, id_flush}, 32'd0);
        drive(0, 1, 1, 32'h300, 0, 0, 0, 1);
        check("dc_rel_load", {31'd0, pc_load}, 32'd1);
        check("dc_rel_tgt", pc_tgt, 32'h300);

        // Reset while in REDIR
        drive(0, 0, 1, 32'h400, 1, 0, 0, 0);
        drive(1, 0, 0, 32'h0, 1, 0, 0, 0);
        idle(0);
        check("rst_redir_no_load", {31'd0, pc_load}, 32'd0);
        check("rst_redir_state", {30'd0, dbg_state}, 32'd0);
        check("rst_redir_cyc", perf_cyc, 32'd0);

        // Reset while in FENCE
        drive(0, 0, 0, 32'h0, 0, 0, 1, 0);
        idle(0);
        drive(1, 0, 0, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            idle(0);
            check("rst_fence_no_done", {31'd0, fence_done}, 32'd0);
            check("rst_fence_if_ce", {31'd0, if_ce}, 32'd1);
        end

        // Branch aborts fence drain
        drive(0, 0, 0, 32'h0, 0, 0, 1, 0);
        idle(0);
        drive(0, 0, 1, 32'h500, 0, 0, 0, 0);
        check("abort_load", {31'd0, pc_load}, 32'd1);
        check("abort_tgt", pc_tgt, 32'h500);
        for (int k = 0; k < 4; k++) begin
            idle(0);
            check("abort_no_done", {31'd0, fence_done}, 32'd0);
        end

        // Latest branch wins in REDIR
        drive(0, 0, 1, 32'h600, 1, 0, 0, 0);
        drive(0, 0, 1, 32'h700, 1, 0, 0, 0);
        idle(0);
        check("latest_load", {31'd0, pc_load}, 32'd1);
        check("latest_tgt", pc_tgt, 32'h700);

        // Random mix, checked by the model every cycle
        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)));
        end
        idle(0);
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
